// File: rtl/restoring_division_param.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, unsigned by default.
// Define RESTORING_DIVISION_SIGNED_EN for two's-complement operands with a sign-fixup cycle.
module restoring_division_param #(
    parameter int N_WIDTH = 8,
    parameter int D_WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_WIDTH-1:0] n_in,
    input  logic [D_WIDTH-1:0] d_in,
    output logic               busy,
    output logic               done,
    output logic [N_WIDTH-1:0] q_out,
    output logic [D_WIDTH-1:0] r_out,
    output logic               div_by_zero,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    localparam int CW = $clog2(N_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_WIDTH - 1);

`ifdef RESTORING_DIVISION_SIGNED_EN
    localparam state_e RUN_EXIT = S_FIX;
`else
    localparam state_e RUN_EXIT = S_FIN;
`endif

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [N_WIDTH-1:0] nq_q;      // dividend bits shift out, quotient bits shift in
    logic [D_WIDTH-1:0] rem_q;
    logic [D_WIDTH-1:0] d_q;
    logic               dz_q;
    logic               busy_q, done_q, div_by_zero_q;
    logic [N_WIDTH-1:0] q_out_q;
    logic [D_WIDTH-1:0] r_out_q;

    logic [N_WIDTH-1:0] n_mag;
    logic [D_WIDTH-1:0] d_mag;

`ifdef RESTORING_DIVISION_SIGNED_EN
    logic n_neg, d_neg;
    logic n_neg_q, q_neg_q;
    assign n_neg = n_in[N_WIDTH-1];
    assign d_neg = d_in[D_WIDTH-1];
    // Most-negative values map to 2^(W-1), which still fits as an unsigned magnitude.
    assign n_mag = n_neg ? -n_in : n_in;
    assign d_mag = d_neg ? -d_in : d_in;
`else
    assign n_mag = n_in;
    assign d_mag = d_in;
`endif

    // Partial remainder is D_WIDTH+1 bits wide only after the shift.
    logic [D_WIDTH:0]   shifted;
    logic [D_WIDTH-1:0] diff_lo;
    logic               trial_ok;
    assign shifted  = {rem_q, nq_q[N_WIDTH-1]};
    assign trial_ok = (shifted >= {1'b0, d_q});
    assign diff_lo  = D_WIDTH'(shifted - {1'b0, d_q});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (d_in == '0) ? S_FIN : S_RUN;
            S_RUN:  if (cnt_q == CNT_LAST) state_d = RUN_EXIT;
            S_FIX:  state_d = S_FIN;
            S_FIN:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            nq_q          <= '0;
            rem_q         <= '0;
            d_q           <= '0;
            dz_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            q_out_q       <= '0;
            r_out_q       <= '0;
`ifdef RESTORING_DIVISION_SIGNED_EN
            n_neg_q       <= 1'b0;
            q_neg_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        d_q    <= d_mag;
                        if (d_in == '0) begin
                            nq_q  <= '1;
                            rem_q <= n_in[D_WIDTH-1:0];
                            dz_q  <= 1'b1;
                        end else begin
                            nq_q  <= n_mag;
                            rem_q <= '0;
                            dz_q  <= 1'b0;
                        end
`ifdef RESTORING_DIVISION_SIGNED_EN
                        n_neg_q <= n_neg;
                        q_neg_q <= n_neg ^ d_neg;
`endif
                    end
                end
                S_RUN: begin
                    nq_q  <= {nq_q[N_WIDTH-2:0], trial_ok};
                    rem_q <= trial_ok ? diff_lo : shifted[D_WIDTH-1:0];
                    cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                end
                S_FIX: begin
`ifdef RESTORING_DIVISION_SIGNED_EN
                    if (q_neg_q) nq_q  <= -nq_q;
                    if (n_neg_q) rem_q <= -rem_q;
`endif
                end
                S_FIN: begin
                    q_out_q       <= nq_q;
                    r_out_q       <= rem_q;
                    div_by_zero_q <= dz_q;
                    done_q        <= 1'b1;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign q_out       = q_out_q;
    assign r_out       = r_out_q;
    assign div_by_zero = div_by_zero_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_restoring_division_param.sv
// Bench for restoring_division_param: vector table, corner sequences, random ops vs arithmetic model.
// Honours RESTORING_DIVISION_SIGNED_EN to select the signed model and latency.
module tb_restoring_division_param;

    localparam int NW = 8;
    localparam int DW = 4;
`ifdef RESTORING_DIVISION_SIGNED_EN
    localparam int LAT = NW + 2;
`else
    localparam int LAT = NW + 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NW-1:0] n_in;
    logic [DW-1:0] d_in;
    logic          busy, done, div_by_zero;
    logic [NW-1:0] q_out;
    logic [DW-1:0] r_out;
    logic [1:0]    state_o;

    int errors = 0;
    int checks = 0;

    restoring_division_param #(.N_WIDTH(NW), .D_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .n_in(n_in), .d_in(d_in),
        .busy(busy), .done(done), .q_out(q_out), .r_out(r_out),
        .div_by_zero(div_by_zero), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] n;
        logic [DW-1:0] d;
        logic [NW-1:0] q;
        logic [DW-1:0] r;
        logic          dz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero convention.
    function automatic void model(input logic [NW-1:0] n, input logic [DW-1:0] d,
                                  output logic [NW-1:0] q, output logic [DW-1:0] r,
                                  output logic dz);
        int sn, sd;
        if (d == '0) begin
            q  = '1;
            r  = n[DW-1:0];
            dz = 1'b1;
        end else begin
            dz = 1'b0;
`ifdef RESTORING_DIVISION_SIGNED_EN
            sn = int'($signed(n));
            sd = int'($signed(d));
`else
            sn = int'(n);
            sd = int'(d);
`endif
            q = NW'(sn / sd);
            r = DW'(sn % sd);
        end
    endfunction

    // Presents start in the current cycle, then follows the op to its done pulse.
    task automatic do_op(input logic [NW-1:0] n, input logic [DW-1:0] d, input string tag);
        logic [NW-1:0] eq, q_hold;
        logic [DW-1:0] er, r_hold;
        logic          edz, held, got;
        int            lat, exp_lat;
        model(n, d, eq, er, edz);
        exp_lat = (d == '0) ? 1 : LAT;
        start = 1'b1;
        n_in  = n;
        d_in  = d;
        @(posedge clk); #1;
        start = 1'b0;
        n_in  = NW'($urandom);
        d_in  = DW'($urandom);
        check({tag, "_busy_set"}, 32'(busy), 32'd1);
        check({tag, "_done_low"}, 32'(done), 32'd0);
        q_hold = q_out;
        r_hold = r_out;
        held = 1'b1;
        got  = 1'b0;
        lat  = 0;
        while (!got && lat < 40) begin
            start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
            if (done) got = 1'b1;
            else if (q_out !== q_hold || r_out !== r_hold || busy !== 1'b1) held = 1'b0;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_hold_run"}, 32'(held), 32'd1);
        check({tag, "_q"}, 32'(q_out), 32'(eq));
        check({tag, "_r"}, 32'(r_out), 32'(er));
        check({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int ndone;
        logic [NW-1:0] qcap;
        logic [DW-1:0] rcap;
        logic ok;

`ifdef RESTORING_DIVISION_SIGNED_EN
        vecs[0] = '{8'hF9, 4'h2, 8'hFD, 4'hF, 1'b0};   // -7 / 2
        vecs[1] = '{8'h80, 4'hF, 8'h80, 4'h0, 1'b0};   // -128 / -1 wraps
        vecs[2] = '{8'h07, 4'hE, 8'hFD, 4'h1, 1'b0};   // 7 / -2
        vecs[3] = '{8'hF8, 4'h8, 8'h01, 4'h0, 1'b0};   // -8 / -8
        vecs[4] = '{8'd100, 4'h0, 8'hFF, 4'h4, 1'b1};
        vecs[5] = '{8'd127, 4'h7, 8'd18, 4'h1, 1'b0};
        vecs[6] = '{8'h9C, 4'h3, 8'hDF, 4'hF, 1'b0};   // -100 / 3
        vecs[7] = '{8'h00, 4'h5, 8'h00, 4'h0, 1'b0};
        vecs[8] = '{8'h80, 4'h8, 8'h10, 4'h0, 1'b0};   // -128 / -8
        vecs[9] = '{8'h09, 4'h2, 8'h04, 4'h1, 1'b0};
`else
        vecs[0] = '{8'd200, 4'd13, 8'd15,  4'd5,  1'b0};
        vecs[1] = '{8'd7,   4'd9,  8'd0,   4'd7,  1'b0};
        vecs[2] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
        vecs[3] = '{8'd100, 4'd0,  8'd255, 4'd4,  1'b1};
        vecs[4] = '{8'd9,   4'd3,  8'd3,   4'd0,  1'b0};
        vecs[5] = '{8'd9,   4'd2,  8'd4,   4'd1,  1'b0};
        vecs[6] = '{8'd0,   4'd15, 8'd0,   4'd0,  1'b0};
        vecs[7] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
        vecs[8] = '{8'd14,  4'd15, 8'd0,   4'd14, 1'b0};
        vecs[9] = '{8'd128, 4'd7,  8'd18,  4'd2,  1'b0};
`endif

        // Reset held with start asserted: nothing may happen.
        reset = 1'b0;
        start = 1'b1;
        n_in  = 8'd50;
        d_in  = 4'd5;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(q_out), 32'd0);
        check("rst_r", 32'(r_out), 32'd0);
        check("rst_dz", 32'(div_by_zero), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;

        // Table vectors, applied back to back (next start in the done cycle).
        for (int i = 0; i < 10; i++) begin
            logic [NW-1:0] mq;
            logic [DW-1:0] mr;
            logic mdz;
            model(vecs[i].n, vecs[i].d, mq, mr, mdz);
            check($sformatf("tab%0d_model", i), {mq, mr, 3'b0, mdz}, {vecs[i].q, vecs[i].r, 3'b0, vecs[i].dz});
            do_op(vecs[i].n, vecs[i].d, $sformatf("tab%0d", i));
            check($sformatf("tab%0d_q_exp", i), 32'(q_out), 32'(vecs[i].q));
            check($sformatf("tab%0d_r_exp", i), 32'(r_out), 32'(vecs[i].r));
        end

        // Start pulsed mid-run must be ignored: exactly one done with the first operands.
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = 8'd50;
        d_in  = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        n_in  = 8'd9;
        d_in  = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        qcap  = '0;
        rcap  = '0;
        repeat (LAT + 6) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                qcap = q_out;
                rcap = r_out;
            end
        end
        check("ign_done_count", 32'(ndone), 32'd1);
        check("ign_q", 32'(qcap), 32'd10);
        check("ign_r", 32'(rcap), 32'd0);

        // Asynchronous reset mid-run abandons the op.
        start = 1'b1;
        n_in  = 8'd50;
        d_in  = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_q", 32'(q_out), 32'd0);
        check("arst_r", 32'(r_out), 32'd0);
        check("arst_state", 32'(state_o), 32'd0);
        start = 1'b1;
        ok = 1'b1;
        repeat (LAT + 2) begin
            @(posedge clk); #1;
            if (done || busy) ok = 1'b0;
        end
        check("arst_quiet", 32'(ok), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        do_op(8'd9, 4'd2, "post_rst");

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            logic [NW-1:0] rn;
            logic [DW-1:0] rd;
            rn = NW'($urandom);
            rd = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
            do_op(rn, rd, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/restoring_division_param.md
RESTORING_DIVISION_PARAM -- requirements
Module: restoring_division_param

Interface
REQ-001 SHALL have parameter N_WIDTH, default 8: dividend and quotient width (>=2).
REQ-002 SHALL have parameter D_WIDTH, default 4: divisor and remainder width (2..N_WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port n_in  input  N_WIDTH  dividend; captured on the accepted start edge.
REQ-007 SHALL have port d_in  input  D_WIDTH  divisor; captured on the accepted start edge.
REQ-008 SHALL have port busy  output  1  high from the accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-010 SHALL have port q_out  output  N_WIDTH  quotient.
REQ-011 SHALL have port r_out  output  D_WIDTH  remainder.
REQ-012 SHALL have port div_by_zero  output  1  set with done when the captured divisor is 0.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> FIN -> IDLE; start=1 in IDLE is accepted, latches operands, enters RUN, sets busy.
REQ-014 SHALL ignore start in RUN and FIN; operand inputs may change freely there without effect.
REQ-015 SHALL resolve one quotient bit per RUN cycle, MSB first, using a D_WIDTH+1-bit partial remainder: shift in the next dividend bit, trial-subtract the divisor, keep the difference and set the quotient bit to 1 if non-negative, else restore and set the bit to 0.
REQ-016 SHALL spend exactly N_WIDTH cycles in RUN, tracked by a counter of width clog2(N_WIDTH+1); it then enters FIN.
REQ-017 In FIN, SHALL update q_out/r_out, pulse done for one cycle, clear busy, and return to IDLE.
REQ-018 Unsigned latency: done high exactly N_WIDTH+1 cycles after the accepting edge; the next start is accepted on the cycle after done.
REQ-019 q_out, r_out and div_by_zero SHALL hold their values from done until the next done; they SHALL NOT change during RUN.
REQ-020 Divisor 0: SHALL skip RUN (IDLE -> FIN) with done 1 cycle after acceptance; q_out = all ones, r_out = n_in[D_WIDTH-1:0], div_by_zero = 1.
REQ-021 div_by_zero SHALL be 0 on every non-zero-divisor result.
REQ-022 Results SHALL satisfy n = q*d + r with r < d for every non-zero divisor.

Reset
REQ-023 reset=0 SHALL force IDLE immediately, independent of clk; busy=0, done=0, q_out=0, r_out=0, div_by_zero=0, counter=0.
REQ-024 Reset mid-operation SHALL abandon the division without a done pulse; after release, start is accepted on the first rising edge.
REQ-025 start asserted while reset=0 SHALL have no effect.

Configuration
REQ-026 Macro RESTORING_DIVISION_SIGNED_EN defined: operands and results SHALL be two's complement; division runs on magnitudes; quotient is negated when operand signs differ (truncation toward zero); remainder takes the dividend's sign.
REQ-027 With the macro, FIN SHALL be preceded by one sign-fixup cycle, giving non-zero-divisor latency N_WIDTH+2; the divide-by-zero path latency is unchanged at 1; the most-negative dividend / -1 SHALL wrap to the most-negative quotient with r_out = 0.
REQ-028 Without the macro, all operands are unsigned and no sign logic SHALL be synthesised.

Verification (defaults N_WIDTH=8, D_WIDTH=4)
REQ-029 n=200, d=13, unsigned -> done 9 cycles after start; q=15, r=5, div_by_zero=0.
REQ-030 n=7, d=9 -> q=0, r=7; then n=255, d=1 started the cycle after done -> q=255, r=0.
REQ-031 n=100, d=0 -> done 1 cycle after start; q=255, r=4, div_by_zero=1.
REQ-032 Start n=50, d=5; 3 cycles later pulse start with n=9, d=3 -> exactly one done, q=10, r=0.
REQ-033 Start n=50, d=5; drop reset at cycle 4 -> outputs 0 immediately, no done; then n=9, d=2 -> q=4, r=1.
REQ-034 SIGNED_EN: n=-7, d=2 -> q=-3, r=-1 at latency 10; n=-128, d=-1 -> q=-128, r=0.
